// File: rtl/centroid_acc_if.sv
// centroid_acc_if: control, mask-memory read port and result/handshake bundle for centroid_acc_mc
interface centroid_acc_if #(
  parameter int IMG_W  = 640,
  parameter int ADDR_W = 9,
  parameter int NCH    = 1,
  parameter int CNT_W  = 20,
  parameter int SUM_W  = 32,
  parameter int NCONS  = 4
);
  logic                   run_acc;
  logic [ADDR_W-1:0]      y_min;
  logic [ADDR_W-1:0]      y_max;
  logic                   acc_done;
  logic [NCH*IMG_W-1:0]   doutb;
  logic [ADDR_W-1:0]      addrb;
  logic                   enb;
  logic [NCH*CNT_W-1:0]   p_size;
  logic [NCH*SUM_W-1:0]   p_x;
  logic [NCH*SUM_W-1:0]   p_y;
  logic [NCH-1:0]         p_ovf;
  logic                   win_err;
  logic                   tvalid;
  logic [NCONS-1:0]       tready;
  modport master (
    output run_acc, y_min, y_max, doutb, tready,
    input  acc_done, addrb, enb, p_size, p_x, p_y, p_ovf, win_err, tvalid
  );
  modport slave (
    input  run_acc, y_min, y_max, doutb, tready,
    output acc_done, addrb, enb, p_size, p_x, p_y, p_ovf, win_err, tvalid
  );
endinterface

// File: rtl/centroid_acc_mc.sv
// centroid_acc_mc: per-channel set-pixel count and x/y coordinate sums over a row window of a binary mask memory
module centroid_acc_mc #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int ADDR_W = 9,
  parameter int NCH    = 1,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 20,
  parameter int SUM_W  = 32,
  parameter int NCONS  = 4
) (
  input logic clk,
  input logic rst,
  centroid_acc_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
  localparam logic [63:0] CNT_MAX = {{(64-CNT_W){1'b0}}, {CNT_W{1'b1}}};
  localparam logic [63:0] SUM_MAX = {{(64-SUM_W){1'b0}}, {SUM_W{1'b1}}};
  logic [1:0]        state;
  logic [ADDR_W-1:0] y_last;
  logic [ADDR_W-1:0] ymax_c;
  logic              bad;
  logic [RD_LAT-1:0] vld;
  logic [ADDR_W-1:0] row [RD_LAT];
  logic [NCONS-1:0]  acc_ok;
  logic [CNT_W-1:0]  sz [NCH];
  logic [CNT_W-1:0]  sz_n [NCH];
  logic [SUM_W-1:0]  sx [NCH];
  logic [SUM_W-1:0]  sx_n [NCH];
  logic [SUM_W-1:0]  sy [NCH];
  logic [SUM_W-1:0]  sy_n [NCH];
  logic [63:0]       pc [NCH];
  logic [63:0]       ix [NCH];
  logic [63:0]       tz [NCH];
  logic [63:0]       tx [NCH];
  logic [63:0]       ty [NCH];
  logic [NCH-1:0]    ovf_n;
  assign ymax_c = 32'(bus.y_max) > IMG_H - 1 ? ADDR_W'(IMG_H - 1) : bus.y_max;
  assign bad = 32'(bus.y_min) >= IMG_H || bus.y_min > ymax_c;
  // sums are formed 64 bits wide so a single row can never wrap before the clamp
  always_comb begin
    ovf_n = '0;
    for (int c = 0; c < NCH; c++) begin
      pc[c] = '0;
      ix[c] = '0;
      for (int i = 0; i < IMG_W; i++) begin
        pc[c] = pc[c] + 64'(bus.doutb[c*IMG_W+i]);
        ix[c] = ix[c] + (bus.doutb[c*IMG_W+i] ? 64'(i) : 64'd0);
      end
      tz[c] = 64'(sz[c]) + pc[c];
      tx[c] = 64'(sx[c]) + ix[c];
      ty[c] = 64'(sy[c]) + pc[c] * 64'(row[RD_LAT-1]);
      ovf_n[c] = tz[c] > CNT_MAX || tx[c] > SUM_MAX || ty[c] > SUM_MAX;
      sz_n[c] = tz[c] > CNT_MAX ? '1 : tz[c][CNT_W-1:0];
      sx_n[c] = tx[c] > SUM_MAX ? '1 : tx[c][SUM_W-1:0];
      sy_n[c] = ty[c] > SUM_MAX ? '1 : ty[c][SUM_W-1:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      y_last <= '0;
      vld <= '0;
      acc_ok <= '0;
      bus.enb <= 1'b0;
      bus.addrb <= '0;
      bus.acc_done <= 1'b0;
      bus.tvalid <= 1'b0;
      bus.win_err <= 1'b0;
      bus.p_ovf <= '0;
      for (int j = 0; j < RD_LAT; j++) row[j] <= '0;
      for (int c = 0; c < NCH; c++) begin
        sz[c] <= '0;
        sx[c] <= '0;
        sy[c] <= '0;
      end
    end else begin
      vld[0] <= bus.enb;
      row[0] <= bus.addrb;
      for (int j = 1; j < RD_LAT; j++) begin
        vld[j] <= vld[j-1];
        row[j] <= row[j-1];
      end
      if (vld[RD_LAT-1] && bus.run_acc) begin
        sz <= sz_n;
        sx <= sx_n;
        sy <= sy_n;
        bus.p_ovf <= bus.p_ovf | ovf_n;
      end
      case (state)
        IDLE: if (bus.run_acc) begin
          state <= READ;
          y_last <= ymax_c;
          bus.win_err <= bad;
          bus.enb <= !bad;
          bus.p_ovf <= '0;
          acc_ok <= '0;
          if (!bad) bus.addrb <= bus.y_min;
          for (int c = 0; c < NCH; c++) begin
            sz[c] <= '0;
            sx[c] <= '0;
            sy[c] <= '0;
          end
        end
        // an empty window idles one cycle in READ so done lands two edges after start
        READ: if (!bus.run_acc) begin
          state <= IDLE;
          bus.enb <= 1'b0;
          vld <= '0;
        end else if (bus.win_err || bus.addrb == y_last) begin
          state <= DRAIN;
          bus.enb <= 1'b0;
        end else begin
          bus.addrb <= bus.addrb + ADDR_W'(1);
        end
        DRAIN: if (!bus.run_acc) begin
          state <= IDLE;
          vld <= '0;
        end else if (vld == '0) begin
          state <= DONE;
          bus.acc_done <= 1'b1;
          bus.tvalid <= 1'b1;
        end
        DONE: if (!bus.run_acc) begin
          state <= IDLE;
          bus.acc_done <= 1'b0;
          bus.tvalid <= 1'b0;
          acc_ok <= '0;
        end else if (bus.tvalid) begin
          acc_ok <= acc_ok | bus.tready;
          if (&(acc_ok | bus.tready)) bus.tvalid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign bus.p_size[g*CNT_W +: CNT_W] = sz[g];
    assign bus.p_x[g*SUM_W +: SUM_W] = sx[g];
    assign bus.p_y[g*SUM_W +: SUM_W] = sy[g];
  end
endmodule

// File: doc/centroid_acc_mc.md
CENTROID_ACC_MC -- requirements
Module: centroid_acc_mc

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning the pixels per mask row, one row per memory word.
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning the rows per frame.
REQ-003 The block SHALL have parameter ADDR_W, default 9, meaning the row-address width.
REQ-004 The block SHALL have parameter NCH, default 1 (range 1..4), meaning the number of mask channels; channel c SHALL occupy doutb[c*IMG_W +: IMG_W], and bit i SHALL be pixel x=i.
REQ-005 The block SHALL have parameter RD_LAT, default 1 (range 1..3), meaning the memory read latency in cycles.
REQ-006 The block SHALL have parameter CNT_W, default 20, meaning the width of each per-channel pixel count.
REQ-007 The block SHALL have parameter SUM_W, default 32, meaning the width of each per-channel coordinate sum.
REQ-008 The block SHALL have parameter NCONS, default 4, meaning the number of downstream consumers (divider inputs).
REQ-009 The block SHALL have port clk, input, 1 bit, the single clock; all logic SHALL run on its rising edge.
REQ-010 The block SHALL have port rst, input, 1 bit, asynchronous, active-high reset.
REQ-011 The block SHALL have port run_acc, input, 1 bit: a level, where high requests a frame and low releases the result.
REQ-012 The block SHALL have ports y_min and y_max, input, ADDR_W bits each, the inclusive row window, sampled at start.
REQ-013 The block SHALL have port acc_done, output, 1 bit, meaning the result is ready.
REQ-014 The block SHALL have port doutb, input, NCH*IMG_W bits, the memory read data.
REQ-015 The block SHALL have ports addrb (output, ADDR_W bits) and enb (output, 1 bit), the memory read port.
REQ-016 The block SHALL have port p_size, output, NCH*CNT_W bits, the per-channel set-pixel counts.
REQ-017 The block SHALL have ports p_x and p_y, output, NCH*SUM_W bits each, the per-channel sums of x and of y.
REQ-018 The block SHALL have port p_ovf, output, NCH bits, the per-channel saturation flags.
REQ-019 The block SHALL have port win_err, output, 1 bit, meaning an empty window.
REQ-020 The block SHALL have port tvalid, output, 1 bit, the result-valid signal to all consumers.
REQ-021 The block SHALL have port tready, input, NCONS bits, the per-consumer ready signals.

Function
REQ-022 The block SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-023 In IDLE with run_acc=1 at edge E0, the block SHALL latch the window, clamping y_max to IMG_H-1, clear accumulators, p_ovf and win_err, and go to READ.
REQ-024 In READ, the block SHALL drive enb=1 and addrb=y_min+k during the k-th READ cycle, one row per cycle, for N=y_max-y_min+1 cycles, then go to DRAIN.
REQ-025 The block SHALL track, via a RD_LAT-deep valid/row-index pipeline, that doutb for the row issued in cycle k is accumulated at the edge ending cycle k+RD_LAT.
REQ-026 Per channel, each row SHALL add popcount to size, add the sum of set-bit indices to sum x, and add popcount*row to sum y.
REQ-027 Each accumulator SHALL saturate at all-ones and set p_ovf[c] sticky for the frame; it SHALL never wrap.
REQ-028 DRAIN SHALL end after the last accumulation; acc_done and tvalid SHALL rise at edge E0+N+RD_LAT+1 and the FSM SHALL enter DONE.
REQ-029 If y_min>y_max after clamping, or y_min>=IMG_H, the block SHALL issue no reads, set win_err=1, and assert acc_done/tvalid at E0+2 with zero results.
REQ-030 The tvalid handshake SHALL keep a per-consumer accepted bit, set at any edge with tvalid=1 and tready[i]=1; consumers MAY accept on different cycles.
REQ-031 Once all NCONS bits are set, including at the same edge they become set, tvalid SHALL go low at that edge and stay low until the next frame.
REQ-032 tvalid SHALL assert at most once per frame.
REQ-033 p_size, p_x, p_y, p_ovf and win_err SHALL hold stable from acc_done rise until the next start.
REQ-034 In DONE, run_acc=0 SHALL clear acc_done and tvalid, clear the accepted bits, and go to IDLE at that edge, even if consumers are pending.
REQ-035 In READ or DRAIN, run_acc=0 SHALL abort to IDLE: enb=0, no acc_done, no tvalid, and in-flight data discarded.
REQ-036 enb SHALL be 0 outside READ, and addrb SHALL hold its last value.

Reset
REQ-037 rst=1 SHALL force IDLE immediately, with acc_done=0, tvalid=0, enb=0, addrb=0, p_size/p_x/p_y=0, p_ovf=0, win_err=0 and accepted bits cleared, in any state.
REQ-038 After rst deasserts with run_acc already high, a frame SHALL start at the first edge.

Verification
REQ-039 The bench SHALL check: NCH=1, RD_LAT=1, window 0..479, single set pixel at (x=5,y=7) -> p_size=1, p_x=5, p_y=7, acc_done at E0+482, 480 reads issued.
REQ-040 The bench SHALL check: NCH=2, all-ones row 10 on channel 1 only, window 10..10 -> ch1 size=640, x=204480, y=6400; ch0 all zero.
REQ-041 The bench SHALL check: RD_LAT=3, window 100..103 -> addrb 100,101,102,103 on consecutive cycles, acc_done at E0+8.
REQ-042 The bench SHALL check: tready bits asserted on cycles +0, +3, +1, +5 after tvalid -> tvalid falls exactly at the +5 edge; run_acc held high -> no second tvalid.
REQ-043 The bench SHALL check: y_min=20, y_max=10 -> win_err=1, enb never high, acc_done at E0+2, results 0.
REQ-044 The bench SHALL check: run_acc dropped mid-READ, then rst pulsed mid-READ on a second frame -> no acc_done/tvalid, all outputs at reset values, next frame correct.
